// File: rtl/fp_normalize_round.sv
// fp_normalize_round: normalize-and-round stage after the FP add/sub datapath.
// Normalizes one bit per cycle, rounds to nearest-even and packs the
// single-precision result together with overflow/underflow/exception flags.
//
// state | meaning
// IDLE  | waiting for an input beat, in_ready high
// NORM  | shifting mantissa toward bit 26, one position per cycle
// ROUND | round to nearest-even, build the packed result
// DONE  | result presented, waiting for out_ready
module fp_normalize_round #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sign,
  input  logic [7:0]      in_exp,
  input  logic [27:0]     in_mant,
  input  logic            in_nan,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            exception
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t          state, state_nxt;
  logic [27:0]     m, m_nxt;
  logic [8:0]      e, e_nxt;
  logic            s, nan;
  logic            ufp, ufp_nxt;

  logic            round_up;
  logic [23:0]     frac_sum;
  logic [8:0]      e_rnd;
  logic [XLEN-1:0] res_nxt;
  logic            ov_nxt, uf_nxt, ex_nxt;

  assign in_ready = (state == IDLE);

  // Rounding datapath; bit 23 of frac_sum is the carry out of the fraction,
  // which only matters when the hidden bit is set (all other paths override it).
  always_comb begin
    round_up = m[2] & (m[1] | m[0] | m[3]);
    frac_sum = {1'b0, m[25:3]} + {23'b0, round_up};
    e_rnd    = frac_sum[23] ? (e + 9'd1) : e;
    res_nxt  = '0;
    ov_nxt   = 1'b0;
    uf_nxt   = 1'b0;
    ex_nxt   = 1'b0;
    if (nan) begin
      res_nxt = 32'h7FC0_0000;
      ex_nxt  = 1'b1;
    end else if (ufp || e_rnd == 9'd0) begin
      res_nxt = {s, 31'b0};
      uf_nxt  = 1'b1;
    end else if (m == 28'd0) begin
      res_nxt = '0;
    end else if (e_rnd >= 9'd255) begin
      res_nxt = {s, 8'hFF, 23'b0};
      ov_nxt  = 1'b1;
    end else begin
      res_nxt = {s, e_rnd[7:0], frac_sum[22:0]};
    end
  end

  // Next-state and working-register updates.
  always_comb begin
    state_nxt = state;
    m_nxt     = m;
    e_nxt     = e;
    ufp_nxt   = ufp;
    case (state)
      IDLE: begin
        if (in_valid) begin
          m_nxt     = in_mant;
          e_nxt     = {1'b0, in_exp};
          ufp_nxt   = 1'b0;
          state_nxt = NORM;
        end
      end
      NORM: begin
        if (nan || m == 28'd0) begin
          state_nxt = ROUND;
        end else if (m[27]) begin
          m_nxt     = {1'b0, m[27:2], m[1] | m[0]};
          e_nxt     = e + 9'd1;
          state_nxt = ROUND;
        end else if (m[26]) begin
          state_nxt = ROUND;
        end else if (e <= 9'd1) begin
          ufp_nxt   = 1'b1;
          state_nxt = ROUND;
        end else begin
          m_nxt = {m[26:0], 1'b0};
          e_nxt = e - 9'd1;
        end
      end
      ROUND: state_nxt = DONE;
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and working registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      m     <= '0;
      e     <= '0;
      ufp   <= 1'b0;
      s     <= 1'b0;
      nan   <= 1'b0;
    end else begin
      state <= state_nxt;
      m     <= m_nxt;
      e     <= e_nxt;
      ufp   <= ufp_nxt;
      if (state == IDLE && in_valid) begin
        s   <= in_sign;
        nan <= in_nan;
      end
    end
  end

  // Registered result, flags and out_valid; held until the consumer accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      exception <= 1'b0;
    end else if (state == ROUND) begin
      out_valid <= 1'b1;
      result    <= res_nxt;
      overflow  <= ov_nxt;
      underflow <= uf_nxt;
      exception <= ex_nxt;
    end else if (state == DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Testbench for fp_normalize_round: directed vectors plus randomized operations
// checked against an arithmetic reference model.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_nan;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        overflow, underflow, exception;

  int errors = 0;
  int checks = 0;

  fp_normalize_round #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_nan(in_nan),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .overflow(overflow), .underflow(underflow), .exception(exception)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Reference: value-level normalize / round-half-even; flags = {ovf, udf, exc}.
  function automatic void model(input logic sg, input logic [7:0] ex, input logic [27:0] mt,
                                input logic nn, output logic [31:0] r,
                                output logic [2:0] fl, output int k);
    longint m, sig, rem;
    int     e, p, need, avail;
    bit     ufp;
    m = longint'(mt); e = int'(ex); k = 0; ufp = 0; r = '0; fl = '0;
    if (nn) begin
      r = 32'h7FC0_0000; fl = 3'b001;
      return;
    end
    if (m != 0) begin
      if (m >= (64'd1 << 27)) begin
        m = (m >> 1) | (m & 1);
        e = e + 1;
      end else if (m < (64'd1 << 26)) begin
        p = 0;
        for (int i = 0; i < 26; i++) if (((m >> i) & 1) != 0) p = i;
        need  = 26 - p;
        avail = (e > 1) ? e - 1 : 0;
        if (need <= avail) k = need;
        else begin k = avail; ufp = 1; end
        m = m << k;
        e = e - k;
      end
    end
    sig = m >> 3;
    rem = m & 7;
    if (rem > 4 || (rem == 4 && (sig & 1) != 0)) sig = sig + 1;
    if (sig >= (64'd1 << 24)) begin sig = sig >> 1; e = e + 1; end
    if (ufp || e == 0) begin
      r = {sg, 31'b0}; fl = 3'b010;
    end else if (m == 0) begin
      r = '0;
    end else if (e >= 255) begin
      r = {sg, 8'hFF, 23'b0}; fl = 3'b100;
    end else begin
      r = {sg, e[7:0], sig[22:0]};
    end
  endfunction

  task automatic run_op(input logic sg, input logic [7:0] ex, input logic [27:0] mt,
                        input logic nn, input int hold);
    logic [31:0] r;
    logic [2:0]  fl;
    int          k, n;
    model(sg, ex, mt, nn, r, fl, k);
    @(negedge clk);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_sign = sg; in_exp = ex; in_mant = mt; in_nan = nn;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_mant = 28'h5A5A5A5; in_exp = 8'h3C; in_sign = ~sg; in_nan = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("latency m=%h e=%h", mt, ex), n, 2 + k);
    chk($sformatf("result m=%h e=%h s=%b n=%b", mt, ex, sg, nn), result, r);
    chk($sformatf("flags m=%h e=%h", mt, ex), {29'b0, overflow, underflow, exception}, {29'b0, fl});
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("hold_result", result, r);
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int          cls, p, hold;
    logic [27:0] mt, mask;
    logic [7:0]  ex;
    bit          seen;

    rst = 1'b1; in_valid = 0; in_sign = 0; in_exp = 0; in_mant = 0; in_nan = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'b0, overflow, underflow, exception}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;

    run_op(1'b0, 8'h80, 28'h4000000, 1'b0, 0);
    run_op(1'b0, 8'h7F, 28'h8000000, 1'b0, 0);
    run_op(1'b0, 8'h7F, 28'h0010000, 1'b0, 0);
    run_op(1'b0, 8'h7F, 28'h400000C, 1'b0, 0);
    run_op(1'b0, 8'h7F, 28'h4000004, 1'b0, 0);
    run_op(1'b0, 8'h7F, 28'h4000006, 1'b0, 0);
    run_op(1'b0, 8'hFE, 28'h7FFFFFC, 1'b0, 0);
    run_op(1'b1, 8'h01, 28'h2000000, 1'b0, 0);
    run_op(1'b0, 8'h40, 28'h4000000, 1'b1, 0);
    run_op(1'b1, 8'h55, 28'h0000000, 1'b0, 0);
    run_op(1'b1, 8'h90, 28'h5123457, 1'b0, 5);

    // Reset in the middle of normalization must abort with no output.
    @(negedge clk);
    in_valid = 1'b1; in_sign = 0; in_exp = 8'h7F; in_mant = 28'h0000100; in_nan = 0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("no_out_after_rst", {31'b0, seen}, 32'd0);

    for (int t = 0; t < 200; t++) begin
      cls  = $urandom_range(0, 9);
      p    = $urandom_range(0, 27);
      mask = (28'd1 << (p + 1)) - 28'd1;
      mt   = (28'($urandom) & mask) | (28'd1 << p);
      if (cls == 0) mt = '0;
      if (cls == 1) ex = 8'($urandom_range(0, 3));
      else if (cls == 2) ex = 8'($urandom_range(250, 255));
      else ex = 8'($urandom_range(0, 255));
      hold = $urandom_range(0, 3);
      run_op(1'($urandom), ex, mt, (cls == 3), hold);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
